// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: sync byte, loader states, frame layout.
package boot_pkg;

  localparam logic [7:0] BOOT_SYNC = 8'hA5;

  // Byte offsets of the frame fields, counted from the sync byte
  localparam int FLD_SYNC   = 0;
  localparam int FLD_LEN_LO = 1;
  localparam int FLD_LEN_HI = 2;
  localparam int FLD_DATA   = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
  } boot_state_t;

  function automatic logic [16:0] frame_len(input logic [7:0] hi, input logic [7:0] lo);
    return {1'b0, hi, lo};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, 1-cycle byte strobe with framing flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     st;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= R_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (st)
        R_IDLE: if (rx_d && !rx_s2) begin
          st  <= R_START;
          cnt <= '0;
        end
        // a start bit that is high again at mid-bit was only a glitch
        R_START: if (cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
          cnt     <= '0;
          bit_idx <= '0;
          st      <= rx_s2 ? R_IDLE : R_DATA;
        end else cnt <= cnt + 1'b1;
        R_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt     <= '0;
          shreg   <= {rx_s2, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) st <= R_STOP;
        end else cnt <= cnt + 1'b1;
        R_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt      <= '0;
          rx_valid <= 1'b1;
          rx_data  <= shreg;
          rx_ferr  <= ~rx_s2;
          st       <= R_IDLE;
        end else cnt <= cnt + 1'b1;
        default: st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Holds the core in reset while a framed image arrives over UART and is written into BRAM port B.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  input  logic              boot_skip,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wstrb,
  output logic              core_resetb,
  output logic              boot_done,
  output logic              boot_err
);
  logic        rx_valid, rx_ferr, rx_ok;
  logic [7:0]  rx_data;

  boot_state_t       state;
  logic              first_cyc;
  logic [7:0]        len_lo, csum;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [16:0]       n_words;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  assign rx_ok   = rx_valid & ~rx_ferr;
  assign n_words = frame_len(rx_data, len_lo);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      first_cyc   <= 1'b1;
      len_lo      <= '0;
      csum        <= '0;
      byte_idx    <= '0;
      last_idx    <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wstrb   <= 4'h0;
      core_resetb <= 1'b0;
      boot_done   <= 1'b0;
      boot_err    <= 1'b0;
    end else begin
      first_cyc <= 1'b0;
      ram_wstrb <= 4'h0;
      case (state)
        ST_IDLE:
          if (first_cyc && boot_skip) state <= ST_DONE;
          else if (rx_ok && rx_data == BOOT_SYNC) state <= ST_LEN_LO;
        ST_LEN_LO: if (rx_ok) begin
          len_lo <= rx_data;
          state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (rx_ok) begin
          last_idx <= ADDR_W'(n_words - 17'd1);
          if (n_words > (17'd1 << ADDR_W)) state <= ST_ERR;
          else if (n_words == 17'd0)       state <= ST_CSUM;
          else                             state <= ST_DATA;
        end
        ST_DATA: begin
          // strobe cycle just finished: advance to the next word or close the image
          if (ram_wstrb == 4'hF) begin
            if (ram_addr == last_idx) state <= ST_CSUM;
            else ram_addr <= ram_addr + 1'b1;
          end
          if (rx_ok) begin
            ram_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
            csum     <= csum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) ram_wstrb <= 4'hF;
          end
        end
        ST_CSUM: if (rx_ok) state <= (rx_data == csum) ? ST_DONE : ST_ERR;
        ST_DONE: begin
          core_resetb <= 1'b1;
          boot_done   <= 1'b1;
        end
        ST_ERR:  boot_err <= 1'b1;
        default: state <= ST_ERR;
      endcase
      // framing error overrides whatever the byte would have done
      if (rx_valid && rx_ferr && state != ST_DONE && state != ST_ERR) state <= ST_ERR;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized + directed bench: frames are parsed by a byte-list reference model and writes compared.
module tb_uart_boot_loader;
  import boot_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, boot_skip = 1'b0;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        core_resetb, boot_done, boot_err;
  logic [1:0]  ram_addr_s;
  logic [31:0] ram_wdata_s;
  logic [3:0]  ram_wstrb_s;
  logic        core_resetb_s, boot_done_s, boot_err_s;

  int checks = 0, errors = 0;
  int bad_l = 0, bad_s = 0, rxv_cnt = 0;
  bit prev_l = 0, prev_s = 0;
  logic [7:0]  tx_q[$];
  bit          fe_q[$];
  logic [63:0] obs_l[$], obs_s[$], exp_q[$], exp_w[$];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(14)) dut_l (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .boot_skip(boot_skip),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .core_resetb(core_resetb), .boot_done(boot_done), .boot_err(boot_err));

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_s (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .boot_skip(boot_skip),
    .ram_addr(ram_addr_s), .ram_wdata(ram_wdata_s), .ram_wstrb(ram_wstrb_s),
    .core_resetb(core_resetb_s), .boot_done(boot_done_s), .boot_err(boot_err_s));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Write monitor: record each strobe, count illegal strobe values and strobes wider than 1 cycle
  always @(negedge clk) if (!reset) begin
    if (ram_wstrb == 4'hF) obs_l.push_back({32'(ram_addr), ram_wdata});
    else if (ram_wstrb != 4'h0) bad_l++;
    if (ram_wstrb == 4'hF && prev_l) bad_l++;
    prev_l = (ram_wstrb == 4'hF);
    if (ram_wstrb_s == 4'hF) obs_s.push_back({32'(ram_addr_s), ram_wdata_s});
    else if (ram_wstrb_s != 4'h0) bad_s++;
    if (ram_wstrb_s == 4'hF && prev_s) bad_s++;
    prev_s = (ram_wstrb_s == 4'hF);
    if (dut_l.u_rx.rx_valid) rxv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_l.delete(); obs_s.delete();
    bad_l = 0; bad_s = 0; rxv_cnt = 0; prev_l = 0; prev_s = 0;
  endtask

  task automatic do_reset(input bit skip);
    @(posedge clk); #1;
    reset = 1'b1; boot_skip = skip; uart_rx = 1'b1;
    tick(3);
    clear_obs();
    reset = 1'b0;
    tick(1);
  endtask

  task automatic add(input logic [7:0] b, input bit fe);
    tx_q.push_back(b); fe_q.push_back(fe);
  endtask

  task automatic new_frame();
    tx_q.delete(); fe_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe);
    uart_rx = 1'b0; tick(CPB);
    for (int k = 0; k < 8; k++) begin uart_rx = b[k]; tick(CPB); end
    uart_rx = !fe; tick(CPB);
    uart_rx = 1'b1; tick(CPB * $urandom_range(1, 2));
  endtask

  task automatic send_all();
    foreach (tx_q[i]) send_byte(tx_q[i], fe_q[i]);
  endtask

  task automatic frame_s1(input logic [7:0] cs);
    new_frame();
    add(8'hA5, 0); add(8'h02, 0); add(8'h00, 0);
    for (int k = 1; k <= 8; k++) add(8'(k * 8'h11), 0);
    add(cs, 0);
  endtask

  // Reference: walk the byte list as a frame; 0 = incomplete, 1 = loaded, 2 = error
  function automatic int model(input int aw);
    int s = 0, i, n, sum = 0;
    logic [31:0] w;
    exp_q.delete();
    while (s < tx_q.size() && !fe_q[s] && tx_q[s] != BOOT_SYNC) s++;
    if (s >= tx_q.size()) return 0;
    if (fe_q[s]) return 2;
    if (s + FLD_LEN_LO < tx_q.size() && fe_q[s + FLD_LEN_LO]) return 2;
    if (s + FLD_LEN_HI >= tx_q.size()) return 0;
    if (fe_q[s + FLD_LEN_HI]) return 2;
    n = int'(tx_q[s + FLD_LEN_LO]) + 256 * int'(tx_q[s + FLD_LEN_HI]);
    if (n > (1 << aw)) return 2;
    i = s + FLD_DATA;
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        if (i >= tx_q.size()) return 0;
        if (fe_q[i]) return 2;
        w = w | (32'(tx_q[i]) << (8 * b));
        sum += int'(tx_q[i]);
        i++;
      end
      exp_q.push_back({32'(k), w});
    end
    if (i >= tx_q.size()) return 0;
    if (fe_q[i] || tx_q[i] != 8'(sum % 256)) return 2;
    return 1;
  endfunction

  task automatic check_all(input string tag, input bit skip);
    int st;
    st = skip ? 1 : model(14);
    if (skip) exp_q.delete();
    exp_w = exp_q;
    chk({tag, ".done"}, boot_done, st == 1);
    chk({tag, ".err"}, boot_err, st == 2);
    chk({tag, ".rstb"}, core_resetb, st == 1);
    chk({tag, ".nwr"}, obs_l.size(), exp_w.size());
    for (int i = 0; i < obs_l.size() && i < exp_w.size(); i++) chk({tag, ".wr"}, obs_l[i], exp_w[i]);
    chk({tag, ".strb"}, bad_l, 0);
    st = skip ? 1 : model(2);
    if (skip) exp_q.delete();
    exp_w = exp_q;
    chk({tag, ".s.done"}, boot_done_s, st == 1);
    chk({tag, ".s.err"}, boot_err_s, st == 2);
    chk({tag, ".s.rstb"}, core_resetb_s, st == 1);
    chk({tag, ".s.nwr"}, obs_s.size(), exp_w.size());
    for (int i = 0; i < obs_s.size() && i < exp_w.size(); i++) chk({tag, ".s.wr"}, obs_s[i], exp_w[i]);
    chk({tag, ".s.strb"}, bad_s, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".addr"}, ram_addr, 0);
    chk({tag, ".wdata"}, ram_wdata, 0);
    chk({tag, ".wstrb"}, ram_wstrb, 0);
    chk({tag, ".rstb"}, core_resetb, 0);
    chk({tag, ".done"}, boot_done, 0);
    chk({tag, ".err"}, boot_err, 0);
  endtask

  initial begin
    // reset state and scenario 1
    do_reset(0);
    check_zero("rst");
    frame_s1(8'h64); send_all(); tick(10);
    check_all("s1", 0);
    if (obs_l.size() == 2) begin
      chk("s1.w0", obs_l[0], {32'd0, 32'h44332211});
      chk("s1.w1", obs_l[1], {32'd1, 32'h88776655});
    end

    // leading junk ignored
    do_reset(0); new_frame();
    add(8'h00, 0); add(8'hFF, 0); add(8'hA5, 0); add(8'h01, 0); add(8'h00, 0);
    add(8'hDE, 0); add(8'hAD, 0); add(8'hBE, 0); add(8'hEF, 0); add(8'h38, 0);
    send_all(); tick(10);
    check_all("s2", 0);

    // bad checksum, trailing bytes must not write
    do_reset(0); frame_s1(8'h65); add(8'h12, 0); add(8'h34, 0); add(8'h56, 0); add(8'h78, 0);
    send_all(); tick(10);
    check_all("s3", 0);

    // length over/at the 4-word limit of the small instance
    do_reset(0); new_frame();
    add(8'hA5, 0); add(8'h05, 0); add(8'h00, 0);
    for (int k = 0; k < 4; k++) add(8'($urandom), 0);
    send_all(); tick(10);
    check_all("s4a", 0);
    do_reset(0); new_frame();
    begin
      logic [7:0] b, sum;
      sum = 0;
      add(8'hA5, 0); add(8'h04, 0); add(8'h00, 0);
      for (int k = 0; k < 16; k++) begin b = 8'($urandom); add(b, 0); sum += b; end
      add(sum, 0);
    end
    send_all(); tick(10);
    check_all("s4b", 0);

    // stop bit low during data
    do_reset(0); frame_s1(8'h64); fe_q[5] = 1;
    send_all(); tick(10);
    check_all("s5a", 0);

    // 1-cycle glitch on idle line, then a normal frame
    do_reset(0);
    uart_rx = 1'b0; tick(1); uart_rx = 1'b1; tick(20);
    chk("glitch.rxv", rxv_cnt, 0);
    check_zero("glitch");
    new_frame();
    add(8'hA5, 0); add(8'h01, 0); add(8'h00, 0);
    add(8'hDE, 0); add(8'hAD, 0); add(8'hBE, 0); add(8'hEF, 0); add(8'h38, 0);
    send_all(); tick(10);
    chk("glitch.nbytes", rxv_cnt, tx_q.size());
    check_all("s5b", 0);

    // boot_skip strap
    do_reset(1); tick(5);
    chk("skip.done", boot_done, 1);
    chk("skip.rstb", core_resetb, 1);
    frame_s1(8'h64); send_all(); tick(10);
    check_all("skip", 1);
    boot_skip = 1'b0;

    // reset in the middle of the image, then retransmit
    do_reset(0); new_frame();
    add(8'hA5, 0); add(8'h02, 0); add(8'h00, 0);
    add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h44, 0);
    send_all(); tick(3);
    chk("mid.nwr", obs_l.size(), 1);
    chk("mid.addr", ram_addr, 1);
    uart_rx = 1'b0; tick(2);
    reset = 1'b1; uart_rx = 1'b1; tick(1);
    check_zero("mid.rst");
    tick(1); clear_obs(); reset = 1'b0; tick(1);
    check_zero("mid.rel");
    frame_s1(8'h64); send_all(); tick(10);
    check_all("mid.re", 0);

    // randomized frames
    for (int it = 0; it < 12; it++) begin
      int n, junk;
      logic [7:0] b, sum;
      do_reset(0); new_frame();
      junk = $urandom_range(0, 2);
      for (int k = 0; k < junk; k++) begin
        b = 8'($urandom);
        if (b == BOOT_SYNC) b = 8'h5A;
        add(b, 0);
      end
      add(BOOT_SYNC, 0);
      n = $urandom_range(0, 6);
      add(n[7:0], 0); add(8'h00, 0);
      sum = 0;
      for (int k = 0; k < 4 * n; k++) begin b = 8'($urandom); add(b, 0); sum += b; end
      if ($urandom_range(0, 3) == 0) sum ^= 8'(1 << $urandom_range(0, 7));
      add(sum, 0);
      add(8'($urandom), 0);
      if ($urandom_range(0, 4) == 0) fe_q[$urandom_range(0, tx_q.size() - 1)] = 1;
      send_all(); tick(12);
      check_all($sformatf("rnd%0d", it), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
